// File: rtl/riscv_ctrl_pkg.sv
// Shared definitions for the multicycle RV32I main controller.
// Holds the controller state enum, the RV32I opcode constants the decoder
// recognises, and the datapath mux-select encodings (ResultSrc, ALUSrcA,
// ALUSrcB, ALUOp). No ports; imported by the controller top.
package riscv_ctrl_pkg;

   // lui and auipc get separate states so that ALUSrcA is a pure function of
   // the registered state.
   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECR    = 4'd6,
      S_EXECI    = 4'd7,
      S_ALUWB    = 4'd8,
      S_BEQ      = 4'd9,
      S_JAL      = 4'd10,
      S_JALR     = 4'd11,
      S_JALWB    = 4'd12,
      S_LUI      = 4'd13,
      S_AUIPC    = 4'd14,
      S_TRAP     = 4'd15
   } state_t;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;

   localparam logic [1:0] RES_ALUOUT    = 2'b00;
   localparam logic [1:0] RES_DATA      = 2'b01;
   localparam logic [1:0] RES_ALURESULT = 2'b10;

   localparam logic [1:0] SRCA_PC    = 2'b00;
   localparam logic [1:0] SRCA_OLDPC = 2'b01;
   localparam logic [1:0] SRCA_RD1   = 2'b10;
   localparam logic [1:0] SRCA_ZERO  = 2'b11;

   localparam logic [1:0] SRCB_RD2  = 2'b00;
   localparam logic [1:0] SRCB_IMM  = 2'b01;
   localparam logic [1:0] SRCB_FOUR = 2'b10;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   // States that hold a memory access open (drive MemReq).
   function automatic logic is_mem_state(input state_t s);
      return (s == S_FETCH) || (s == S_MEMREAD) || (s == S_MEMWRITE);
   endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Memory wait-state counter with timeout compare.
// Ports:
//   i_clk        clock, rising edge
//   i_rst_n      asynchronous active-low reset
//   i_mem_req    a memory access is in progress this cycle
//   i_mem_ready  memory completes the access this cycle
//   o_timeout    this cycle is the MEM_TIMEOUT-th consecutive wait cycle
//                of the current access (never set when MEM_TIMEOUT = 0)
// The count restarts at zero whenever no access is waiting, so every new
// access (fetch, load or store) starts from zero.
module mem_wait_timer #(
   parameter int MEM_TIMEOUT = 16
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_mem_req,
   input  logic i_mem_ready,
   output logic o_timeout
);

   localparam int CW = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
   localparam logic [CW-1:0] LAST = CW'(MEM_TIMEOUT - 1);

   logic [CW-1:0] cnt;
   logic          waiting;

   assign waiting = i_mem_req & ~i_mem_ready;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         cnt <= '0;
      end else if (waiting) begin
         cnt <= cnt + 1'b1;
      end else begin
         cnt <= '0;
      end
   end

   // Fires while the count is about to reach MEM_TIMEOUT; a ready in the
   // same cycle clears "waiting" and so suppresses the trap.
   generate
      if (MEM_TIMEOUT == 0) begin : g_no_timeout
         assign o_timeout = 1'b0;
      end else begin : g_timeout
         assign o_timeout = waiting && (cnt == LAST);
      end
   endgenerate

endmodule

// File: rtl/multicycle_main_fsm.sv
// Main controller of the multicycle RV32I core (Moore FSM).
// Sequences fetch/decode/execute/memory/writeback and drives the datapath
// enables and mux selects. Traps (absorbing until reset) on an illegal
// opcode or on a memory wait-state timeout.
// Ports:
//   i_clk, i_rst_n   clock (rising edge), asynchronous active-low reset
//   i_op             opcode field of the instruction register
//   i_mem_ready      memory completes the current access this cycle
//   o_PCUpdate, o_Branch, o_IRWrite, o_AdrSrc, o_MemWrite, o_MemReq,
//   o_ResultSrc, o_ALUSrcA, o_ALUSrcB, o_ALUOp, o_RegWrite
//                    datapath controls (all 0 while i_rst_n is low)
//   o_instr_done     one-cycle pulse when an instruction retires
//   o_illegal        sticky illegal-opcode trap flag
//   o_bus_err        sticky memory-timeout trap flag
//   o_dbg_state      current FSM state, for debug and checkers
// Optional feature macro PERF_CNT_EN adds o_cycle_cnt / o_instret_cnt.
//
// Handshake: a memory access is open while o_MemReq=1; it completes in the
// cycle i_mem_ready=1, and the FSM leaves the memory state on that edge.
module multicycle_main_fsm
   import riscv_ctrl_pkg::*;
#(
   parameter int U_TYPE_EN   = 1,
   parameter int MEM_TIMEOUT = 16,
   parameter int CNT_W       = 32
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic [6:0]       i_op,
   input  logic             i_mem_ready,
   output logic             o_PCUpdate,
   output logic             o_Branch,
   output logic             o_IRWrite,
   output logic             o_AdrSrc,
   output logic             o_MemWrite,
   output logic             o_MemReq,
   output logic [1:0]       o_ResultSrc,
   output logic [1:0]       o_ALUSrcA,
   output logic [1:0]       o_ALUSrcB,
   output logic [1:0]       o_ALUOp,
   output logic             o_RegWrite,
   output logic             o_instr_done,
   output logic             o_illegal,
   output logic             o_bus_err,
`ifdef PERF_CNT_EN
   output logic [CNT_W-1:0] o_cycle_cnt,
   output logic [CNT_W-1:0] o_instret_cnt,
`endif
   output logic [3:0]       o_dbg_state
);

   // A zero-width performance counter is not a meaningful configuration.
   if (CNT_W < 1) begin : g_bad_cnt_w
      $error("CNT_W must be at least 1");
   end

   state_t     state, state_next;
   logic       mem_req, timeout;
   logic       pc_update, branch, ir_write, adr_src, mem_write;
   logic       reg_write, instr_done, set_illegal, set_bus_err;
   logic [1:0] result_src, alu_src_a, alu_src_b, alu_op;
   logic       illegal_q, bus_err_q;

   // Derived from state alone so the timer's timeout does not feed back
   // into the block that produces its request input.
   assign mem_req = is_mem_state(state);

   mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
      .i_clk       (i_clk),
      .i_rst_n     (i_rst_n),
      .i_mem_req   (mem_req),
      .i_mem_ready (i_mem_ready),
      .o_timeout   (timeout)
   );

   always_comb begin
      state_next  = state;
      pc_update   = 1'b0;
      branch      = 1'b0;
      ir_write    = 1'b0;
      adr_src     = 1'b0;
      mem_write   = 1'b0;
      reg_write   = 1'b0;
      instr_done  = 1'b0;
      set_illegal = 1'b0;
      set_bus_err = 1'b0;
      result_src  = RES_ALUOUT;
      alu_src_a   = SRCA_PC;
      alu_src_b   = SRCB_RD2;
      alu_op      = ALUOP_ADD;
      unique case (state)
         S_FETCH: begin
            alu_src_b  = SRCB_FOUR;
            result_src = RES_ALURESULT;
            // IR and PC load only in the cycle the fetch data arrives.
            ir_write   = i_mem_ready;
            pc_update  = i_mem_ready;
            if (i_mem_ready) begin
               state_next = S_DECODE;
            end else if (timeout) begin
               state_next  = S_TRAP;
               set_bus_err = 1'b1;
            end
         end
         S_DECODE: begin
            alu_src_a = SRCA_OLDPC;
            alu_src_b = SRCB_IMM;
            case (i_op)
               OP_LOAD, OP_STORE: state_next = S_MEMADR;
               OP_R:              state_next = S_EXECR;
               OP_I:              state_next = S_EXECI;
               OP_BRANCH:         state_next = S_BEQ;
               OP_JAL:            state_next = S_JAL;
               OP_JALR:           state_next = S_JALR;
               OP_LUI, OP_AUIPC: begin
                  if (U_TYPE_EN != 0) begin
                     state_next = (i_op == OP_LUI) ? S_LUI : S_AUIPC;
                  end else begin
                     state_next  = S_TRAP;
                     set_illegal = 1'b1;
                  end
               end
               default: begin
                  state_next  = S_TRAP;
                  set_illegal = 1'b1;
               end
            endcase
         end
         S_MEMADR: begin
            alu_src_a  = SRCA_RD1;
            alu_src_b  = SRCB_IMM;
            // Bit 5 separates store (0100011) from load (0000011).
            state_next = i_op[5] ? S_MEMWRITE : S_MEMREAD;
         end
         S_MEMREAD: begin
            adr_src = 1'b1;
            if (i_mem_ready) begin
               state_next = S_MEMWB;
            end else if (timeout) begin
               state_next  = S_TRAP;
               set_bus_err = 1'b1;
            end
         end
         S_MEMWB: begin
            result_src = RES_DATA;
            reg_write  = 1'b1;
            instr_done = 1'b1;
            state_next = S_FETCH;
         end
         S_MEMWRITE: begin
            adr_src   = 1'b1;
            mem_write = 1'b1;
            if (i_mem_ready) begin
               instr_done = 1'b1;
               state_next = S_FETCH;
            end else if (timeout) begin
               state_next  = S_TRAP;
               set_bus_err = 1'b1;
            end
         end
         S_EXECR, S_EXECI: begin
            alu_src_a  = SRCA_RD1;
            alu_src_b  = (state == S_EXECI) ? SRCB_IMM : SRCB_RD2;
            alu_op     = ALUOP_FUNCT;
            state_next = S_ALUWB;
         end
         S_ALUWB: begin
            reg_write  = 1'b1;
            instr_done = 1'b1;
            state_next = S_FETCH;
         end
         S_BEQ: begin
            alu_src_a  = SRCA_RD1;
            alu_op     = ALUOP_SUB;
            branch     = 1'b1;
            instr_done = 1'b1;
            state_next = S_FETCH;
         end
         S_JAL: begin
            alu_src_a  = SRCA_OLDPC;
            alu_src_b  = SRCB_FOUR;
            pc_update  = 1'b1;
            state_next = S_ALUWB;
         end
         S_JALR: begin
            alu_src_a  = SRCA_RD1;
            alu_src_b  = SRCB_IMM;
            result_src = RES_ALURESULT;
            pc_update  = 1'b1;
            state_next = S_JALWB;
         end
         S_JALWB: begin
            // Link value rd = OldPC + 4 goes straight from the ALU.
            alu_src_a  = SRCA_OLDPC;
            alu_src_b  = SRCB_FOUR;
            result_src = RES_ALURESULT;
            reg_write  = 1'b1;
            instr_done = 1'b1;
            state_next = S_FETCH;
         end
         S_LUI, S_AUIPC: begin
            alu_src_a  = (state == S_LUI) ? SRCA_ZERO : SRCA_OLDPC;
            alu_src_b  = SRCB_IMM;
            state_next = S_ALUWB;
         end
         S_TRAP: begin
            state_next = S_TRAP;
         end
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state     <= S_FETCH;
         illegal_q <= 1'b0;
         bus_err_q <= 1'b0;
`ifdef PERF_CNT_EN
         o_cycle_cnt   <= '0;
         o_instret_cnt <= '0;
`endif
      end else begin
         state <= state_next;
         if (set_illegal) illegal_q <= 1'b1;
         if (set_bus_err) bus_err_q <= 1'b1;
`ifdef PERF_CNT_EN
         if (state != S_TRAP) begin
            o_cycle_cnt <= o_cycle_cnt + 1'b1;
            if (instr_done) o_instret_cnt <= o_instret_cnt + 1'b1;
         end
`endif
      end
   end

   // The reset state is FETCH, so controls are masked while reset is held.
   assign o_PCUpdate   = i_rst_n & pc_update;
   assign o_Branch     = i_rst_n & branch;
   assign o_IRWrite    = i_rst_n & ir_write;
   assign o_AdrSrc     = i_rst_n & adr_src;
   assign o_MemWrite   = i_rst_n & mem_write;
   assign o_MemReq     = i_rst_n & mem_req;
   assign o_ResultSrc  = {2{i_rst_n}} & result_src;
   assign o_ALUSrcA    = {2{i_rst_n}} & alu_src_a;
   assign o_ALUSrcB    = {2{i_rst_n}} & alu_src_b;
   assign o_ALUOp      = {2{i_rst_n}} & alu_op;
   assign o_RegWrite   = i_rst_n & reg_write;
   assign o_instr_done = i_rst_n & instr_done;
   assign o_illegal    = illegal_q;
   assign o_bus_err    = bus_err_q;
   assign o_dbg_state  = state;

endmodule
